// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   8N1 UART receive stage. Synchronises the asynchronous rx line, detects a
//   start bit, samples every bit at mid-bit and presents the recovered byte
//   with a one-cycle valid strobe. A low stop bit raises a one-cycle framing
//   error; the line must then return high before a new frame is accepted.
//
//   Optional feature (macro UART_RX_MAJORITY_EN): each sample point takes
//   the 2-of-3 majority of rx_s at nominal -1/0/+1 cycles, which moves every
//   decision one cycle later. Needs CLKS_PER_BIT >= 4.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (1..65535)
// Ports
//   clk           system clock, posedge
//   rst_n         asynchronous active-low reset
//   rx            serial line, asynchronous, idle high
//   dout          last good byte, held until the next good frame
//   rx_valid      one-cycle pulse, dout updated
//   rx_frame_err  one-cycle pulse, stop bit sampled low
//   rx_busy       high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_RX_MAJORITY_EN
    localparam int SKEW = 1;
    if (CLKS_PER_BIT < 4) begin : g_bad_cfg
        $error("uart_receiver: majority sampling needs CLKS_PER_BIT >= 4");
    end
`else
    localparam int SKEW = 0;
`endif

    // The counter is cleared on the edge that leaves t0 (or the previous
    // sample), so the sample cycle is reached when it equals N-1.
    localparam logic [CW-1:0] START_LAST = CW'((HALF > 0) ? HALF - 1 + SKEW : 0);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t          state, state_next;
    logic            sync1, rx_s;
    logic            samp;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            shift_en, load, valid_next, err_next;

    // Two-flop synchroniser, runs in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Decision taken at nominal+1: rx_s is the +1 sample, hist1 nominal,
    // hist2 nominal-1.
    logic hist1, hist2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist1 <= 1'b1;
            hist2 <= 1'b1;
        end else begin
            hist1 <= rx_s;
            hist2 <= hist1;
        end
    end
    assign samp = (rx_s & hist1) | (rx_s & hist2) | (hist1 & hist2);
`else
    assign samp = rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        load       = 1'b0;
        valid_next = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                // With one clock per bit the low level at t0 is the start check.
                if (!rx_s) state_next = (HALF == 0) ? DATA : START;
            end
            START: begin
                if (cnt == START_LAST) state_next = samp ? IDLE : DATA;
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    if (samp) begin
                        load       = 1'b1;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: cycle counter, bit counter, shift register, outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            dout         <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (state_next != state || state == IDLE || state == BREAK)
                cnt <= '0;
            else if (cnt == BIT_LAST)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            // Wraps 7 -> 0 on the last data bit, so DATA always starts at 0.
            if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {samp, shreg[7:1]};
            end

            if (load) dout <= shreg;
            rx_valid     <= valid_next;
            rx_frame_err <= err_next;
        end
    end

    assign rx_busy = (state != IDLE);

endmodule
